// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - in-order pipeline hazard control: forwarding selects, load/multi-cycle stalls, branch flush
module pipe_hazard_ctrl #(
  parameter int STAGES    = 5,
  parameter int RA_W      = 5,
  parameter int LOAD_DIST = 2,
  parameter int MC_W      = 6,
  localparam int NR       = STAGES - 1,
  localparam int D_W      = $clog2(STAGES - 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic            id_wr,
  input  logic [RA_W-1:0] id_waddr,
  input  logic            id_load,
  input  logic            id_mc,
  input  logic [MC_W-1:0] id_mc_cyc,
  input  logic            branch_taken,
  output logic [NR-1:0]   n_stall,
  output logic [NR-1:0]   flush,
  output logic [D_W-1:0]  fwd_rs,
  output logic [D_W-1:0]  fwd_rt,
  output logic            mc_busy,
  output logic [15:0]     stall_cnt
);

  // Entry d describes the instruction d positions ahead of ID (1 = EX).
  logic [NR-1:1]   trk_valid;
  logic [NR-1:1]   trk_load;
  logic [RA_W-1:0] trk_waddr [1:NR-1];
  logic [MC_W-1:0] mc_cnt;

  logic rs_ld;
  logic rt_ld;
  logic load_stall;
  logic stalled;

  // Scan far-to-near so the nearest matching writer wins.
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    rs_ld  = 1'b0;
    rt_ld  = 1'b0;
    for (int d = NR - 1; d >= 1; d--) begin
      if (id_rs_used && (id_rs != '0) && trk_valid[d] && (trk_waddr[d] == id_rs)) begin
        fwd_rs = D_W'(d);
        rs_ld  = trk_load[d] && (d < LOAD_DIST);
      end
      if (id_rt_used && (id_rt != '0) && trk_valid[d] && (trk_waddr[d] == id_rt)) begin
        fwd_rt = D_W'(d);
        rt_ld  = trk_load[d] && (d < LOAD_DIST);
      end
    end
  end

  always_comb begin
    mc_busy    = (mc_cnt != '0);
    load_stall = (rs_ld || rt_ld) && !branch_taken;
    n_stall    = '1;
    flush      = '0;
    if (!enable) begin
      n_stall = '0;
    end else if (mc_busy) begin
      n_stall[NR-1] = 1'b0;
      n_stall[NR-2] = 1'b0;
      flush[NR-3]   = 1'b1;
    end else if (branch_taken) begin
      flush[NR-1] = 1'b1;
      flush[NR-2] = 1'b1;
    end else if (load_stall) begin
      // Hold PC and IF/ID; a bubble enters ID/EX.
      n_stall[NR-1] = 1'b0;
      flush[NR-2]   = 1'b1;
    end
    stalled = enable && (n_stall != '1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      trk_valid <= '0;
      trk_load  <= '0;
      for (int d = 1; d <= NR - 1; d++) trk_waddr[d] <= '0;
      mc_cnt    <= '0;
      stall_cnt <= '0;
    end else if (enable) begin
      if (stalled && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (mc_busy) begin
        // Multi-cycle op stays in EX; downstream drains behind a bubble.
        mc_cnt <= mc_cnt - MC_W'(1);
        for (int d = NR - 1; d >= 3; d--) begin
          trk_valid[d] <= trk_valid[d-1];
          trk_load[d]  <= trk_load[d-1];
          trk_waddr[d] <= trk_waddr[d-1];
        end
        trk_valid[2] <= 1'b0;
        trk_load[2]  <= 1'b0;
        trk_waddr[2] <= '0;
      end else begin
        for (int d = NR - 1; d >= 2; d--) begin
          trk_valid[d] <= trk_valid[d-1];
          trk_load[d]  <= trk_load[d-1];
          trk_waddr[d] <= trk_waddr[d-1];
        end
        if (branch_taken || load_stall) begin
          trk_valid[1] <= 1'b0;
          trk_load[1]  <= 1'b0;
          trk_waddr[1] <= '0;
        end else begin
          trk_valid[1] <= id_valid && id_wr && (id_waddr != '0);
          trk_load[1]  <= id_load;
          trk_waddr[1] <= id_waddr;
          if (id_valid && id_mc && (id_mc_cyc >= MC_W'(2))) mc_cnt <= id_mc_cyc - MC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl (STAGES=5, LOAD_DIST=2)
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, enable, id_valid, id_rs_used, id_rt_used, id_wr, id_load, id_mc, branch_taken;
  logic [4:0]  id_rs, id_rt, id_waddr;
  logic [5:0]  id_mc_cyc;
  logic [3:0]  n_stall, flush;
  logic [1:0]  fwd_rs, fwd_rt;
  logic        mc_busy;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wr(id_wr), .id_waddr(id_waddr), .id_load(id_load), .id_mc(id_mc),
    .id_mc_cyc(id_mc_cyc), .branch_taken(branch_taken),
    .n_stall(n_stall), .flush(flush), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .mc_busy(mc_busy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic en, v, rsu, rtu, wr, ld, mc, br;
    logic [4:0] rs, rt, wa;
    logic [5:0] cyc;
    logic [3:0] e_ns, e_fl;
    logic [1:0] e_frs, e_frt;
    logic e_mb;
    logic [15:0] e_sc;
  } vec_t;

  typedef struct {
    bit v;
    int wa;
    bit ld;
  } ent_t;

  // Reference: instructions in flight ahead of ID, index 0 = EX.
  ent_t pipe[$];
  int   m_mc_left;
  int   m_sc;

  function automatic vec_t mk(int en, int v, int rsu, int rs, int rtu, int rt, int wr, int wa,
                              int ld, int mc, int cyc, int br, logic [3:0] ns, logic [3:0] fl,
                              int frs, int frt, int mb, int sc);
    vec_t r;
    r.en = en[0]; r.v = v[0]; r.rsu = rsu[0]; r.rs = rs[4:0]; r.rtu = rtu[0]; r.rt = rt[4:0];
    r.wr = wr[0]; r.wa = wa[4:0]; r.ld = ld[0]; r.mc = mc[0]; r.cyc = cyc[5:0]; r.br = br[0];
    r.e_ns = ns; r.e_fl = fl; r.e_frs = frs[1:0]; r.e_frt = frt[1:0]; r.e_mb = mb[0];
    r.e_sc = sc[15:0];
    return r;
  endfunction

  task automatic drive(input vec_t r, input logic rst_v);
    rst = rst_v; enable = r.en; id_valid = r.v; id_rs_used = r.rsu; id_rs = r.rs;
    id_rt_used = r.rtu; id_rt = r.rt; id_wr = r.wr; id_waddr = r.wa; id_load = r.ld;
    id_mc = r.mc; id_mc_cyc = r.cyc; branch_taken = r.br;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input vec_t r, input int idx);
    chk("n_stall", idx, 32'(n_stall), 32'(r.e_ns));
    chk("flush", idx, 32'(flush), 32'(r.e_fl));
    chk("fwd_rs", idx, 32'(fwd_rs), 32'(r.e_frs));
    chk("fwd_rt", idx, 32'(fwd_rt), 32'(r.e_frt));
    chk("mc_busy", idx, 32'(mc_busy), 32'(r.e_mb));
    chk("stall_cnt", idx, 32'(stall_cnt), 32'(r.e_sc));
  endtask

  function automatic void model_reset();
    ent_t b;
    b.v = 1'b0; b.wa = 0; b.ld = 1'b0;
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(b);
    m_mc_left = 0;
    m_sc = 0;
  endfunction

  function automatic int nearest(int a, bit used, output bit is_ld);
    is_ld = 1'b0;
    if (!used || a == 0) return 0;
    foreach (pipe[i]) if (pipe[i].v && pipe[i].wa == a) begin
      is_ld = pipe[i].ld && (i + 1 < 2);
      return i + 1;
    end
    return 0;
  endfunction

  // Expected outputs from the current model state and applied inputs.
  function automatic vec_t model_expect(vec_t r, output bit ldh);
    vec_t e = r;
    bit l1, l2;
    e.e_frs = 2'(nearest(int'(r.rs), r.rsu, l1));
    e.e_frt = 2'(nearest(int'(r.rt), r.rtu, l2));
    e.e_mb  = (m_mc_left != 0);
    ldh = (l1 || l2) && !r.br;
    if (!r.en)          begin e.e_ns = 4'b0000; e.e_fl = 4'b0000; end
    else if (e.e_mb)    begin e.e_ns = 4'b0011; e.e_fl = 4'b0010; end
    else if (r.br)      begin e.e_ns = 4'b1111; e.e_fl = 4'b1100; end
    else if (ldh)       begin e.e_ns = 4'b0111; e.e_fl = 4'b0100; end
    else                begin e.e_ns = 4'b1111; e.e_fl = 4'b0000; end
    e.e_sc = 16'(m_sc);
    return e;
  endfunction

  function automatic void model_edge(vec_t r, logic rst_v, vec_t e, bit ldh);
    ent_t b, n;
    b.v = 1'b0; b.wa = 0; b.ld = 1'b0;
    if (!rst_v) begin model_reset(); return; end
    if (!r.en) return;
    if (e.e_ns != 4'b1111 && m_sc < 65535) m_sc++;
    if (m_mc_left != 0) begin
      m_mc_left--;
      pipe.insert(1, b);
      pipe.delete(pipe.size() - 1);
    end else begin
      n.v = r.v && r.wr && (r.wa != 0); n.wa = int'(r.wa); n.ld = r.ld;
      pipe.push_front((r.br || ldh) ? b : n);
      pipe.delete(pipe.size() - 1);
      if (!r.br && !ldh && r.v && r.mc && r.cyc >= 2) m_mc_left = int'(r.cyc) - 1;
    end
  endfunction

  vec_t tbl[$];
  vec_t idle, cur, exp_v;
  bit   ldh;
  logic rst_r;

  initial begin
    idle = mk(1,0,0,0,0,0,0,0,0,0,0,0, 4'b1111,4'b0000,0,0,0,0);

    // Reset with junk inputs, then check the idle outputs.
    drive(mk(1,1,1,3,1,3,1,3,1,1,5,0, 0,0,0,0,0,0), 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(idle, 1'b1);
    #1 chk_all(idle, -1);

    //              en v rsu rs rtu rt wr wa ld mc cyc br   n_stall  flush   frs frt mb sc
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 0, 4'b1111,4'b0000,0,0,0,0));
    tbl.push_back(mk(1,1,1,1, 1,2, 1,3, 0,0,0, 0, 4'b1111,4'b0000,0,0,0,0));
    tbl.push_back(mk(1,1,1,3, 1,3, 1,4, 0,0,0, 0, 4'b1111,4'b0000,1,1,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,6, 0,0,0, 0, 4'b1111,4'b0000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 0, 4'b1111,4'b0000,0,0,0,0));
    tbl.push_back(mk(1,1,1,6, 1,6, 0,0, 0,0,0, 0, 4'b1111,4'b0000,2,2,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,0, 1,0,0, 0, 4'b1111,4'b0000,0,0,0,0));
    tbl.push_back(mk(1,1,1,0, 1,0, 0,0, 0,0,0, 0, 4'b1111,4'b0000,0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,5, 1,0,0, 0, 4'b1111,4'b0000,0,0,0,0));
    tbl.push_back(mk(1,1,1,5, 1,7, 0,0, 0,0,0, 0, 4'b0111,4'b0100,1,0,0,0));
    tbl.push_back(mk(1,1,1,5, 1,7, 0,0, 0,0,0, 0, 4'b1111,4'b0000,2,0,0,1));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,8, 1,0,0, 0, 4'b1111,4'b0000,0,0,0,1));
    tbl.push_back(mk(1,1,1,8, 0,0, 0,0, 0,0,0, 1, 4'b1111,4'b1100,1,0,0,1));
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 0, 4'b1111,4'b0000,0,0,0,1));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,9, 0,1,4, 0, 4'b1111,4'b0000,0,0,0,1));
    tbl.push_back(mk(1,1,1,9, 0,0, 0,0, 0,0,0, 0, 4'b0011,4'b0010,1,0,1,1));
    tbl.push_back(mk(1,1,1,9, 0,0, 0,0, 0,0,0, 1, 4'b0011,4'b0010,1,0,1,2));
    tbl.push_back(mk(1,1,1,9, 0,0, 0,0, 0,0,0, 0, 4'b0011,4'b0010,1,0,1,3));
    tbl.push_back(mk(1,1,1,9, 0,0, 0,0, 0,0,0, 0, 4'b1111,4'b0000,1,0,0,4));
    tbl.push_back(mk(1,1,0,0, 0,0, 0,0, 0,1,1, 0, 4'b1111,4'b0000,0,0,0,4));
    tbl.push_back(mk(1,1,0,0, 0,0, 0,0, 0,1,0, 0, 4'b1111,4'b0000,0,0,0,4));
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 0, 4'b1111,4'b0000,0,0,0,4));
    tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 0,0,0, 1, 4'b0000,4'b0000,0,0,0,4));
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,0, 0, 4'b1111,4'b0000,0,0,0,4));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i], 1'b1);
      #1 chk_all(tbl[i], i);
      @(posedge clk);
    end

    // Reset landing on the second busy cycle of a 4-cycle op.
    @(negedge clk);
    drive(mk(1,1,0,0,0,0,1,9,0,1,4,0, 0,0,0,0,0,0), 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(mk(1,1,1,9,0,0,0,0,0,0,0,0, 0,0,0,0,0,0), 1'b1);
    #1 chk("mc_busy_c1", 100, 32'(mc_busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mc_busy_c2", 101, 32'(mc_busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mc_busy", 102, 32'(mc_busy), 32'd0);
    chk("rst_stall_cnt", 102, 32'(stall_cnt), 32'd0);
    chk("rst_fwd_rs", 102, 32'(fwd_rs), 32'd0);
    chk("rst_n_stall", 102, 32'(n_stall), 32'hF);

    // Randomized phase against the queue model, starting from reset.
    model_reset();
    @(negedge clk);
    drive(idle, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 600; i++) begin
      cur = mk(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) != 0),
               $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 5), $urandom_range(0, 7) == 0,
               0, 0, 0, 0, 0, 0);
      rst_r = ($urandom_range(0, 59) != 0);
      @(negedge clk);
      drive(cur, rst_r);
      #1;
      exp_v = model_expect(cur, ldh);
      chk_all(exp_v, 1000 + i);
      @(posedge clk);
      model_edge(cur, rst_r, exp_v, ldh);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
